nes_snes_poller: RTL
====================

Name: nes_snes_poller

Overview:
- Upstream front-end of the controller peripheral: generates the controller latch/clock waveform and shifts in the serial button stream from an NES or SNES pad.
- Delivers decoded, active-high button states plus a one-cycle valid strobe to the register stage that the TinyQV core reads.
- Polls autonomously at a fixed rate; software can also request an immediate poll.

Parameters:
- POLL_PERIOD, 1066667: clk cycles between automatic polls (60 Hz at 64 MHz); internal counter is 21 bits.
- LATCH_CYCLES, 768: ctrl_latch high duration (12 us at 64 MHz).
- HALF_BIT_CYCLES, 384: half period of ctrl_clk (6 us at 64 MHz).

Ports:
- clk  in  1  system clock, 64 MHz
- rst_n  in  1  synchronous, active-low reset
- snes_mode  in  1  0 = NES (8 bits), 1 = SNES (16 bits); sampled when a poll starts
- poll_now  in  1  single-cycle request for an immediate poll
- ctrl_data  in  1  serial data from pad, active-low, already synchronised
- ctrl_latch  out  1  latch to pad
- ctrl_clk  out  1  shift clock to pad, idles high
- std_buttons  out  8  {A,B,Select,Start,Up,Down,Left,Right}, A at bit 7, 1 = pressed
- ext_buttons  out  4  {X,Y,L,R}, X at bit 3, 1 = pressed; always 0 in NES mode
- busy  out  1  high from first latch cycle through the DONE cycle
- valid  out  1  one-cycle pulse when outputs have been updated

Behaviour:
- Reset, with rst_n low at a clock edge: state IDLE, poll counter 0, ctrl_latch=0, ctrl_clk=1, std_buttons=0, ext_buttons=0, busy=0, valid=0, shift register cleared. Reset applied mid-poll aborts the poll with no output update.
- Poll counter:
  - Free-runs 0..POLL_PERIOD-1 and raises a tick on wrap.
  - A poll starts in IDLE on tick OR poll_now. Tick and poll_now in the same cycle start exactly one poll.
  - Tick or poll_now while busy is ignored; it is not queued.
- Poll start: mode_r <= snes_mode; n = mode_r ? 16 : 8. Let L=LATCH_CYCLES, H=HALF_BIT_CYCLES, and cycle 0 = first cycle with ctrl_latch=1.
- States:
  - LATCH: ctrl_latch=1 for cycles 0..L-1.
  - SETTLE: ctrl_latch=0, ctrl_clk=1 for H cycles. Raw bit 0 is captured from ctrl_data at the edge ending cycle L+H-1.
  - CLK_LOW: ctrl_clk=0 for H cycles.
  - CLK_HIGH: ctrl_clk=1 for H cycles. Raw bit k is captured at the edge ending the last CLK_HIGH cycle. Loop CLK_LOW→CLK_HIGH for k=1..n-1, giving n-1 clock pulses in total.
  - DONE: one cycle, at cycle L+H+2H(n-1). Decode and register outputs at its ending edge, then return to IDLE.
  - Outputs and valid are visible in cycle L+H+2H(n-1)+1. busy falls that same cycle.
- Decode (pressed = ~raw):
  - NES raw order 0..7: A,B,Select,Start,Up,Down,Left,Right.
  - SNES raw order 0..11: B,Y,Select,Start,Up,Down,Left,Right,A,X,L,R. Raw bits 12..15 are captured and ignored.
  - NES mode forces ext_buttons=0.
- Outputs hold their value between polls. A changed snes_mode during a poll has no effect until the next poll start.
- Floating data line (no pad, pulled high) decodes as all released, which is valid behaviour.

Optional Feature:
- Macro: NES_SNES_POLLER_DEBOUNCE_EN.
- Enabled:
  - The block keeps the previous poll's decoded 12-bit vector.
  - std_buttons/ext_buttons update only when the current decode equals the previous decode, i.e. two consecutive matching polls.
  - valid pulses only on cycles where outputs change value or are confirmed after a mismatch.
  - The previous-vector register resets to 0.
- Disabled: outputs update on every completed poll and valid pulses on every completed poll.

Test Plan:
1. Reset/defaults (POLL_PERIOD=400, L=8, H=4): hold rst_n low 5 cycles → ctrl_latch=0, ctrl_clk=1, std_buttons=0x00, ext_buttons=0x0, busy=0, valid=0.
2. NES read: poll_now pulse, snes_mode=0, pad drives raw 8'b0111_1110 (A and Right pressed, bit 0 first) → ctrl_latch high 8 cycles, exactly 7 ctrl_clk low pulses of 4 cycles each, valid in cycle 69, std_buttons=0x81, ext_buttons=0x0.
3. SNES read: snes_mode=1, raw bits 0..15 give B, X, R pressed and 12..15 = 1 → 15 clock pulses, valid in cycle 133, std_buttons=0x40, ext_buttons=0x9.
4. Collision: assert poll_now on the same cycle as tick → one poll only. Assert poll_now mid-poll (cycle 20) → ignored, single valid pulse.
5. Reset mid-poll: drop rst_n at cycle 30 of an SNES poll → immediate IDLE, ctrl_clk=1, outputs 0, no valid. The next tick polls normally.
6. With NES_SNES_POLLER_DEBOUNCE_EN: poll 1 reads A pressed (outputs stay 0x00). Poll 2 reads A pressed → std_buttons=0x80 with valid. Poll 3 reads released → outputs hold 0x80.

Source files
------------

// File: rtl/nes_snes_poller.sv
// NES/SNES pad poller: drives latch/clock to the pad, shifts in the serial button stream, decodes it.
// Optional build macro NES_SNES_POLLER_DEBOUNCE_EN: outputs change only after two matching polls.
module nes_snes_poller #(
  parameter int POLL_PERIOD     = 1066667,
  parameter int LATCH_CYCLES    = 768,
  parameter int HALF_BIT_CYCLES = 384
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       snes_mode,
  input  logic       poll_now,
  input  logic       ctrl_data,
  output logic       ctrl_latch,
  output logic       ctrl_clk,
  output logic [7:0] std_buttons,
  output logic [3:0] ext_buttons,
  output logic       busy,
  output logic       valid
);

  localparam int TMAX = (LATCH_CYCLES > HALF_BIT_CYCLES) ? LATCH_CYCLES : HALF_BIT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {IDLE, LATCH, SETTLE, CLK_LOW, CLK_HIGH, DONE} state_t;

  state_t      state_q;
  logic [20:0] poll_cnt_q;
  logic [TW-1:0] timer_q;
  logic [3:0]  bit_q;
  logic        mode_q;
  logic [11:0] raw_q;
  logic        latch_q;
  logic        sclk_q;
  logic [7:0]  std_q;
  logic [3:0]  ext_q;
  logic        busy_q;
  logic        valid_q;

  logic        tick;
  logic        latch_end;
  logic        half_end;
  logic [3:0]  last_bit;
  logic [11:0] pressed;
  logic [11:0] dec_d;

`ifdef NES_SNES_POLLER_DEBOUNCE_EN
  logic [11:0] prev_q;
  logic        pend_q;
`endif

  assign tick      = (poll_cnt_q == 21'(POLL_PERIOD - 1));
  assign latch_end = (timer_q == TW'(LATCH_CYCLES - 1));
  assign half_end  = (timer_q == TW'(HALF_BIT_CYCLES - 1));
  assign last_bit  = mode_q ? 4'd15 : 4'd7;
  assign pressed   = ~raw_q;

  // Decoded vector is {std_buttons, ext_buttons}; the pad sends bits active-low.
  always_comb begin
    if (mode_q) begin
      dec_d = {pressed[8], pressed[0], pressed[2], pressed[3], pressed[4], pressed[5],
               pressed[6], pressed[7], pressed[9], pressed[1], pressed[10], pressed[11]};
    end else begin
      dec_d = {pressed[0], pressed[1], pressed[2], pressed[3], pressed[4], pressed[5],
               pressed[6], pressed[7], 4'b0000};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      poll_cnt_q <= '0;
    end else if (tick) begin
      poll_cnt_q <= '0;
    end else begin
      poll_cnt_q <= poll_cnt_q + 21'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      mode_q  <= 1'b0;
      raw_q   <= '0;
      latch_q <= 1'b0;
      sclk_q  <= 1'b1;
      std_q   <= '0;
      ext_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
`ifdef NES_SNES_POLLER_DEBOUNCE_EN
      prev_q  <= '0;
      pend_q  <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      timer_q <= timer_q + TW'(1);
      case (state_q)
        IDLE: begin
          timer_q <= '0;
          if (tick || poll_now) begin
            state_q <= LATCH;
            mode_q  <= snes_mode;
            bit_q   <= '0;
            raw_q   <= '0;
            latch_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        LATCH: begin
          if (latch_end) begin
            state_q <= SETTLE;
            timer_q <= '0;
            latch_q <= 1'b0;
          end
        end
        SETTLE: begin
          if (half_end) begin
            raw_q[0] <= ctrl_data;
            bit_q    <= 4'd1;
            timer_q  <= '0;
            sclk_q   <= 1'b0;
            state_q  <= CLK_LOW;
          end
        end
        CLK_LOW: begin
          if (half_end) begin
            timer_q <= '0;
            sclk_q  <= 1'b1;
            state_q <= CLK_HIGH;
          end
        end
        // SNES bits 12..15 are clocked out of the pad but not stored.
        CLK_HIGH: begin
          if (half_end) begin
            if (bit_q < 4'd12) begin
              raw_q[bit_q] <= ctrl_data;
            end
            timer_q <= '0;
            if (bit_q == last_bit) begin
              state_q <= DONE;
            end else begin
              bit_q   <= bit_q + 4'd1;
              sclk_q  <= 1'b0;
              state_q <= CLK_LOW;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
`ifdef NES_SNES_POLLER_DEBOUNCE_EN
          prev_q <= dec_d;
          if (dec_d == prev_q) begin
            {std_q, ext_q} <= dec_d;
            valid_q        <= (dec_d != {std_q, ext_q}) || pend_q;
            pend_q         <= 1'b0;
          end else begin
            pend_q <= 1'b1;
          end
`else
          {std_q, ext_q} <= dec_d;
          valid_q        <= 1'b1;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ctrl_latch  = latch_q;
  assign ctrl_clk    = sclk_q;
  assign std_buttons = std_q;
  assign ext_buttons = ext_q;
  assign busy        = busy_q;
  assign valid       = valid_q;

endmodule
